reg16: RTL and testbench



---
 rtl/cpu_pkg.sv | 16 +
 rtl/dff_en.sv | 35 +++
 rtl/reg16.sv | 45 ++++
 tb/tb_reg16.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared datapath definitions for the JALA-CPU.
//   WORD_W    : native datapath word width in bits
//   word_t    : one datapath word
//   WORD_ZERO : all-zero word, the usual reset value for datapath state
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_ZERO = '0;

endpackage : cpu_pkg

// File: rtl/dff_en.sv
// -----------------------------------------------------------------------------
// dff_en
// Single-bit D flip-flop with clock enable and asynchronous active-low reset.
// This is the bit-slice cell of the datapath registers.
//
// Parameters:
//   RESET_VALUE : value forced onto q while rst_n is low
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset, priority over en
//   en    in  1  load enable; only a clean 1 loads, anything else holds
//   d     in  1  data to load
//   q     out 1  stored bit
// -----------------------------------------------------------------------------
module dff_en #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    // An X or Z on en makes the if condition false in simulation, so the
    // stored bit is held instead of being corrupted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : dff_en

// File: rtl/reg16.sv
// -----------------------------------------------------------------------------
// reg16
// General-purpose storage register with write enable, used for register-file
// entries, PC, IR and temporaries. Built as WIDTH independent dff_en bit
// slices so it matches the schematic bit-slice layout. O comes straight from
// the flops; there is no combinational path from I to O.
//
// Parameters:
//   WIDTH       : data width (16 = one cpu_pkg::word_t)
//   RESET_VALUE : value loaded while rst_n is low
// Ports:
//   clk   in  1      rising-edge clock
//   rst_n in  1      asynchronous active-low reset, priority over Write
//   I     in  WIDTH  data to store
//   Write in  1      write enable, active-high, sampled on rising clk
//   O     out WIDTH  current stored value, visible one edge after a write
// -----------------------------------------------------------------------------
module reg16
    import cpu_pkg::*;
#(
    parameter int                 WIDTH       = WORD_W,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic             Write,
    output logic [WIDTH-1:0] O
);

    // With the default WIDTH the port types are exactly word_t.

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        dff_en #(
            .RESET_VALUE (RESET_VALUE[b])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (Write),
            .d     (I[b]),
            .q     (O[b])
        );
    end

endmodule : reg16

// File: tb/tb_reg16.sv
// -----------------------------------------------------------------------------
// tb_reg16
// Directed self-checking bench for reg16. Inputs change on the falling clock
// edge; O is checked 1 time unit after the rising edge, or shortly before it
// when the pre-edge (old) value is wanted.
// -----------------------------------------------------------------------------
module tb_reg16;
    import cpu_pkg::*;

    logic  clk;
    logic  rst_n;
    word_t din;
    logic  wr;
    word_t dout;

    int errors;
    int checks;

    reg16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (din),
        .Write (wr),
        .O     (dout)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, then sample 1 unit after the next rising edge.
    task automatic drive(input word_t d, input logic w);
        @(negedge clk);
        din = d;
        wr  = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 16'hBEEF;
        wr    = 1'b1;
        #1;
        checks++;
        if (dout !== WORD_ZERO) begin
            errors++;
            $display("FAIL reset_immediate: got %h expected %h", dout, WORD_ZERO);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dout !== WORD_ZERO) begin
                errors++;
                $display("FAIL reset_held edge %0d: got %h expected %h", k, dout, WORD_ZERO);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL reset_release_load: got %h expected %h", dout, 16'hBEEF);
        end
    endtask

    task automatic test_basic_write();
        drive(16'h1234, 1'b1);
        // Just before the sampling edge the old value must still be there.
        #4;
        checks++;
        if (dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_pre_edge: got %h expected %h", dout, 16'hBEEF);
        end
        step();
        checks++;
        if (dout !== 16'h1234) begin
            errors++;
            $display("FAIL write_post_edge: got %h expected %h", dout, 16'h1234);
        end
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            drive(word_t'(v), 1'b0);
            step();
            checks++;
            if (dout !== 16'h1234) begin
                errors++;
                bad++;
                if (bad <= 4)
                    $display("FAIL hold I=%h: got %h expected %h", word_t'(v), dout, 16'h1234);
            end
        end
    endtask

    task automatic test_alternating();
        word_t exp;
        word_t cur;
        logic  w;
        exp = 16'h1234;
        for (int k = 0; k < 16; k++) begin
            cur = 16'h3000 + word_t'(k);
            w   = (k % 2 == 0);
            drive(cur, w);
            // Wiggle I mid-cycle after the edge sample point; must not matter.
            step();
            if (w) exp = cur;
            checks++;
            if (dout !== exp) begin
                errors++;
                $display("FAIL alternating k=%0d write=%0b: got %h expected %h", k, w, dout, exp);
            end
            din = ~cur;
        end
    endtask

    task automatic test_boundary();
        word_t vals[3];
        vals[0] = 16'hFFFF;
        vals[1] = 16'h0000;
        vals[2] = 16'h8001;
        for (int k = 0; k < 3; k++) begin
            drive(vals[k], 1'b1);
            step();
            checks++;
            if (dout !== vals[k]) begin
                errors++;
                $display("FAIL boundary %0d: got %h expected %h", k, dout, vals[k]);
            end
        end
    endtask

    task automatic test_x_write();
        drive(16'h5555, 1'bx);
        step();
        checks++;
        if (dout !== 16'h8001) begin
            errors++;
            $display("FAIL write_x_hold: got %h expected %h", dout, 16'h8001);
        end
        drive(16'hAAAA, 1'bz);
        step();
        checks++;
        if (dout !== 16'h8001) begin
            errors++;
            $display("FAIL write_z_hold: got %h expected %h", dout, 16'h8001);
        end
    endtask

    task automatic test_reset_mid();
        drive(16'hA5A5, 1'b1);
        step();
        checks++;
        if (dout !== 16'hA5A5) begin
            errors++;
            $display("FAIL mid_write: got %h expected %h", dout, 16'hA5A5);
        end
        // Pending write of 7777 is cut by the reset pulse between edges.
        @(negedge clk);
        din = 16'h7777;
        wr  = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== WORD_ZERO) begin
            errors++;
            $display("FAIL mid_reset_async: got %h expected %h", dout, WORD_ZERO);
        end
        wr = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (dout !== WORD_ZERO) begin
                errors++;
                $display("FAIL mid_after_release %0d: got %h expected %h", k, dout, WORD_ZERO);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            drive(word_t'(16'h0101 * (k + 1)), 1'b1);
            step();
            checks++;
            if (dout !== word_t'(16'h0101 * (k + 1))) begin
                errors++;
                $display("FAIL back_to_back %0d: got %h expected %h", k, dout, word_t'(16'h0101 * (k + 1)));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_write();
        test_hold();
        test_alternating();
        test_boundary();
        test_x_write();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg16
